// File: rtl/bdspi_pkg.sv
// Shared definitions for the SPI backdoor bridge: FSM state codes and the
// encoding of the header's R/W flag.
package bdspi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_HDR   = 3'd1;
    localparam state_t ST_WDATA = 3'd2;
    localparam state_t ST_RLOAD = 3'd3;
    localparam state_t ST_RDATA = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/backdoor_spi_bridge_if.sv
// SPI pins plus the user-module side of the backdoor bridge.
// Optional BDSPI_FRAME_ERR_EN adds the sticky o_FRAME_ERR flag.
interface backdoor_spi_bridge_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int N_MODULES     = 4
);
    logic                             i_BCLK;
    logic                             i_SS;
    logic                             i_MOSI;
    logic [DATA_WIDTH*N_MODULES-1:0]  i_MODULE_DATA;
    logic                             o_MISO;
    logic [ADDRESS_WIDTH-2:0]         o_ADDR;
    logic [DATA_WIDTH-1:0]            o_DATA_IN;
    logic                             o_DOUT_VALID;
    logic [N_MODULES-1:0]             o_MODULE_WE;
`ifdef BDSPI_FRAME_ERR_EN
    logic                             o_FRAME_ERR;
`endif

    modport slave (
        input  i_BCLK, i_SS, i_MOSI, i_MODULE_DATA,
        output o_MISO, o_ADDR, o_DATA_IN, o_DOUT_VALID, o_MODULE_WE
`ifdef BDSPI_FRAME_ERR_EN
        , output o_FRAME_ERR
`endif
    );

    modport master (
        output i_BCLK, i_SS, i_MOSI, i_MODULE_DATA,
        input  o_MISO, o_ADDR, o_DATA_IN, o_DOUT_VALID, o_MODULE_WE
`ifdef BDSPI_FRAME_ERR_EN
        , input o_FRAME_ERR
`endif
    );
endinterface

// File: rtl/bdspi_sync.sv
// Multi-flop synchronizer for BCLK/SS/MOSI plus BCLK edge detection on the
// synchronized copy. All three lines share one pipeline so they stay aligned.
module bdspi_sync #(
    parameter int BUFFER_WIDTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic ss,
    input  logic mosi,
    output logic ss_sync,
    output logic mosi_sync,
    output logic bclk_rise,
    output logic bclk_fall
);
    // Stage bits are {bclk, ss, mosi}; SS resets high so nothing looks selected.
    logic [2:0] stage_reg [BUFFER_WIDTH];
    logic       bclk_prev_reg;
    logic       bclk_sync;

    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= 3'b010;
                    else        stage_reg[gi] <= {bclk, ss, mosi};
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= 3'b010;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign bclk_sync = stage_reg[BUFFER_WIDTH-1][2];
    assign ss_sync   = stage_reg[BUFFER_WIDTH-1][1];
    assign mosi_sync = stage_reg[BUFFER_WIDTH-1][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bclk_prev_reg <= 1'b0;
        else        bclk_prev_reg <= bclk_sync;
    end

    assign bclk_rise = bclk_sync & ~bclk_prev_reg;
    assign bclk_fall = ~bclk_sync & bclk_prev_reg;
endmodule

// File: rtl/backdoor_spi_bridge.sv
// SPI-slave backdoor into N user modules, fully synchronous to i_SYSCLK.
// Define BDSPI_FRAME_ERR_EN to get a sticky incomplete-frame flag.
module backdoor_spi_bridge
    import bdspi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int N_MODULES     = 4,
    parameter int BUFFER_WIDTH  = 2
) (
    input  logic              i_SYSCLK,
    input  logic              i_RST_N,
    backdoor_spi_bridge_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH - 1;
    localparam int CW = $clog2(DATA_WIDTH + ADDRESS_WIDTH);

    logic ss_sync, mosi_sync, bclk_rise, bclk_fall;

    bdspi_sync #(.BUFFER_WIDTH(BUFFER_WIDTH)) u_sync (
        .clk       (i_SYSCLK),
        .rst_n     (i_RST_N),
        .bclk      (bus.i_BCLK),
        .ss        (bus.i_SS),
        .mosi      (bus.i_MOSI),
        .ss_sync   (ss_sync),
        .mosi_sync (mosi_sync),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  rw_reg;
    logic [AW-1:0]         addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  armed_reg;
`ifdef BDSPI_FRAME_ERR_EN
    logic                  err_reg;
`endif

    // Address a in 1..N_MODULES selects module a-1; anything else selects none.
    logic [N_MODULES-1:0]  sel;
    logic [DATA_WIDTH-1:0] masked [N_MODULES];
    logic [DATA_WIDTH-1:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < N_MODULES; gi++) begin : g_sel
            assign sel[gi]    = (addr_reg == AW'(gi + 1));
            assign masked[gi] = sel[gi] ? bus.i_MODULE_DATA[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_MODULES; k++) rd_word = rd_word | masked[k];
    end

    always_ff @(posedge i_SYSCLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            shift_reg <= '0;
            armed_reg <= 1'b0;
`ifdef BDSPI_FRAME_ERR_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            if (ss_sync) begin
                // Deselect aborts the frame; latched address/data are kept.
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                armed_reg <= 1'b0;
`ifdef BDSPI_FRAME_ERR_EN
                if (state_reg inside {ST_HDR, ST_WDATA, ST_RLOAD, ST_RDATA}) err_reg <= 1'b1;
`endif
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_HDR;
                        cnt_reg   <= '0;
                    end
                    ST_HDR: if (bclk_rise) begin
                        if (cnt_reg == '0) begin
                            rw_reg  <= mosi_sync;
`ifdef BDSPI_FRAME_ERR_EN
                            err_reg <= 1'b0;
`endif
                        end else begin
                            addr_reg <= {addr_reg[AW-2:0], mosi_sync};
                        end
                        if (cnt_reg == CW'(ADDRESS_WIDTH - 1)) begin
                            cnt_reg <= '0;
                            case (rw_reg)
                                RW_READ:  state_reg <= ST_RLOAD;
                                RW_WRITE: state_reg <= ST_WDATA;
                                default:  state_reg <= ST_IDLE;
                            endcase
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    ST_WDATA: if (bclk_rise) begin
                        data_reg <= {data_reg[DATA_WIDTH-2:0], mosi_sync};
                        if (cnt_reg == CW'(DATA_WIDTH - 1)) begin
                            valid_reg <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    ST_RLOAD: begin
                        shift_reg <= rd_word;
                        armed_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_RDATA;
                    end
                    ST_RDATA: begin
                        // The trailing header falling edge arrives before arming and is ignored.
                        if (!armed_reg && bclk_rise) begin
                            armed_reg <= 1'b1;
                        end else if (armed_reg && bclk_fall) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                            if (cnt_reg == CW'(DATA_WIDTH - 1)) state_reg <= ST_DONE;
                            else                                 cnt_reg   <= cnt_reg + CW'(1);
                        end
                    end
                    ST_DONE: ;
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_MISO       = shift_reg[DATA_WIDTH-1];
    assign bus.o_ADDR       = addr_reg;
    assign bus.o_DATA_IN    = data_reg;
    assign bus.o_DOUT_VALID = valid_reg;
    assign bus.o_MODULE_WE  = {N_MODULES{valid_reg}} & sel;
`ifdef BDSPI_FRAME_ERR_EN
    assign bus.o_FRAME_ERR  = err_reg;
`endif
endmodule

// File: tb/tb_backdoor_spi_bridge.sv
// Bench for backdoor_spi_bridge: drives SPI frames as a master and checks
// strobes, read words and latched values against a frame-level model.
module tb_backdoor_spi_bridge;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NM = 4;
    localparam int BW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    backdoor_spi_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .N_MODULES(NM)) bus ();

    backdoor_spi_bridge #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .N_MODULES(NM), .BUFFER_WIDTH(BW)
    ) dut (
        .i_SYSCLK (clk),
        .i_RST_N  (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  we;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q [$];
    logic [31:0] mdata [NM];

    logic [31:0] dir_rd   [4] = '{32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888};
    logic [31:0] dir_wd   [4] = '{32'h12345678, 32'hF0F0F0F0, 32'h00000000, 32'hFFFFFFFF};
    logic [3:0]  dir_we   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_mdata();
        for (int k = 0; k < NM; k++) bus.i_MODULE_DATA[k*DW +: DW] = mdata[k];
    endtask

    // Frame-level model: what a read returns and which enable a write raises.
    function automatic logic [31:0] model_rd(input int a);
        if (a >= 1 && a <= NM) return mdata[a-1];
        return 32'h0;
    endfunction

    function automatic logic [3:0] model_we(input int a);
        if (a >= 1 && a <= NM) return 4'(1 << (a - 1));
        return 4'b0;
    endfunction

    task automatic do_frame(input logic rw, input int a, input logic [31:0] d, input int h,
                            input int stall, input int abort_at, input int extra,
                            input logic [31:0] want_rd, input logic [3:0] want_we, input string tag);
        logic [7:0]  hdr;
        logic [31:0] got;
        bit          aborted;
        wr_t         e;
        hdr     = {rw, a[6:0]};
        got     = '0;
        aborted = 0;
        bus.i_SS = 1'b0;
        cyc(h);
        for (int i = 7; i >= 0; i--) begin
            bus.i_MOSI = hdr[i];
            cyc(h);
            bus.i_BCLK = 1'b1;
            cyc(h);
            bus.i_BCLK = 1'b0;
        end
        check({tag, "_hdr_addr"}, 64'(bus.o_ADDR), 64'(a[6:0]));
`ifdef BDSPI_FRAME_ERR_EN
        check({tag, "_err_clear"}, 64'(bus.o_FRAME_ERR), 64'd0);
`endif
        cyc(stall);
        if (rw == 1'b0) begin
            for (int n = 0; n < 32; n++) begin
                if (n == abort_at) begin
                    aborted = 1;
                    break;
                end
                bus.i_MOSI = d[31-n];
                cyc(h);
                if (n == 31) begin
                    e.addr = a[6:0];
                    e.data = d;
                    e.we   = want_we;
                    exp_q.push_back(e);
                end
                bus.i_BCLK = 1'b1;
                cyc(h);
                bus.i_BCLK = 1'b0;
            end
        end else begin
            for (int n = 0; n < 32; n++) begin
                cyc(h);
                bus.i_BCLK = 1'b1;
                cyc(h);
                got[31-n] = bus.o_MISO;
                bus.i_BCLK = 1'b0;
            end
            check({tag, "_rd_word"}, 64'(got), 64'(want_rd));
        end
        for (int x = 0; x < extra; x++) begin
            bus.i_MOSI = ~bus.i_MOSI;
            cyc(h);
            bus.i_BCLK = 1'b1;
            cyc(h);
            bus.i_BCLK = 1'b0;
        end
        cyc(4);
        bus.i_SS = 1'b1;
        cyc(8);
        if (rw == 1'b0 && !aborted) check({tag, "_strobe_pending"}, 64'(exp_q.size()), 64'd0);
`ifdef BDSPI_FRAME_ERR_EN
        check({tag, "_frame_err"}, 64'(bus.o_FRAME_ERR), 64'(aborted));
`endif
        $display("frame %s rw=%0d addr=%0d half=%0d stall=%0d data=%08h miso=%08h aborted=%0d",
                 tag, rw, a, h, stall, d, got, aborted);
    endtask

    initial begin
        int hs [3];
        bus.i_BCLK = 1'b0;
        bus.i_SS   = 1'b1;
        bus.i_MOSI = 1'b0;
        for (int k = 0; k < NM; k++) mdata[k] = dir_rd[k];
        apply_mdata();

        // Every cycle: enables stay low unless a strobe is due, and each strobe matches one expected write.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (bus.o_DOUT_VALID) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_strobe", 64'd1, 64'd0);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("strobe_addr", 64'(bus.o_ADDR), 64'(e.addr));
                            check("strobe_data", 64'(bus.o_DATA_IN), 64'(e.data));
                            check("strobe_we", 64'(bus.o_MODULE_WE), 64'(e.we));
                        end
                    end else begin
                        check("we_idle", 64'(bus.o_MODULE_WE), 64'd0);
                    end
                end
            end
        join_none

        cyc(3);
        check("rst_miso", 64'(bus.o_MISO), 64'd0);
        check("rst_addr", 64'(bus.o_ADDR), 64'd0);
        check("rst_data", 64'(bus.o_DATA_IN), 64'd0);
        check("rst_valid", 64'(bus.o_DOUT_VALID), 64'd0);
        check("rst_we", 64'(bus.o_MODULE_WE), 64'd0);
`ifdef BDSPI_FRAME_ERR_EN
        check("rst_err", 64'(bus.o_FRAME_ERR), 64'd0);
`endif
        rst_n = 1'b1;
        cyc(5);
        check("post_rst_valid", 64'(bus.o_DOUT_VALID), 64'd0);

        hs[0] = 6;
        hs[1] = 40;
        hs[2] = int'($urandom_range(3, 10));
        foreach (hs[s]) begin
            for (int a = 1; a <= 4; a++)
                do_frame(1'b1, a, 32'h0, hs[s], 15, -1, 0, dir_rd[a-1], 4'b0, "dir_rd");
            for (int a = 1; a <= 4; a++)
                do_frame(1'b0, a, dir_wd[a-1], hs[s], 15, -1, 0, 32'h0, dir_we[a-1], "dir_wr");
        end

        do_frame(1'b1, 0, 32'h0, 6, 15, -1, 0, 32'h0, 4'b0, "rd_addr0");
        do_frame(1'b1, 7, 32'h0, 6, 15, -1, 0, 32'h0, 4'b0, "rd_addr7");
        do_frame(1'b0, 5, 32'hA5A5A5A5, 6, 15, -1, 0, 32'h0, 4'b0000, "wr_addr5");
        do_frame(1'b0, 3, 32'hDEADBEEF, 6, 10, 20, 0, 32'h0, 4'b0100, "abort");
        do_frame(1'b0, 2, 32'hCAFEF00D, 6, 10, -1, 0, 32'h0, 4'b0010, "after_abort");

        for (int r = 0; r < 16; r++) begin
            logic rw;
            int   a;
            logic [31:0] d;
            for (int k = 0; k < NM; k++) mdata[k] = $urandom;
            apply_mdata();
            rw = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 7));
            d  = $urandom;
            do_frame(rw, a, d, int'($urandom_range(3, 10)), int'($urandom_range(0, 20)), -1,
                     int'($urandom_range(0, 3)), model_rd(a), model_we(a), "rnd");
        end

        cyc(10);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/backdoor_spi_bridge.md
Name: backdoor_spi_bridge

Overview:
SPI-slave backdoor into the user area, fully synchronous to the system clock.
- Serial frame: one R/W flag bit, a 7-bit address, then 32 data bits.
- A write presents address and data and pulses a one-hot write enable to the addressed module.
- A read parallel-loads the addressed module's 32-bit word and shifts it out on MISO.
- Sits between the external SPI pins and N user modules.

Parameters:
- ADDRESS_WIDTH, 8: frame header width (1 R/W bit + ADDRESS_WIDTH-1 address bits).
- DATA_WIDTH, 32: data word width.
- N_MODULES, 4: number of addressable user modules.
- BUFFER_WIDTH, 2: synchronizer depth for i_BCLK, i_SS and i_MOSI.

Ports:
- i_SYSCLK, in, 1: the single clock; every flop is clocked by it.
- i_RST_N, in, 1: reset, asynchronous, active-low.
- i_BCLK, in, 1: SPI clock, sampled as data. Idle-low, master changes MOSI on falling edges.
- i_SS, in, 1: slave select, active-low.
- i_MOSI, in, 1: serial data in, MSB first.
- i_MODULE_DATA, in, DATA_WIDTH*N_MODULES: module k's word is at [k*DATA_WIDTH +: DATA_WIDTH].
- o_MISO, out, 1: serial read data, MSB first.
- o_ADDR, out, ADDRESS_WIDTH-1: latched address.
- o_DATA_IN, out, DATA_WIDTH: latched write data.
- o_DOUT_VALID, out, 1: write-complete strobe.
- o_MODULE_WE, out, N_MODULES: one-hot per-module write enable.

Behaviour:
- Reset: all outputs 0, shift registers 0, FSM in IDLE.
- Input conditioning: i_BCLK, i_SS and i_MOSI each pass through a BUFFER_WIDTH-flop synchronizer. Rising and falling BCLK edges are detected on the synchronized copy.
- Clocking requirement: BCLK high and low phases each ≥ BUFFER_WIDTH+1 SYSCLK periods.
- MOSI is sampled on detected BCLK rising edges.
- SS high (synchronized): FSM returns to IDLE and counters clear. o_ADDR and o_DATA_IN hold their values; o_DOUT_VALID and o_MODULE_WE are 0. This is an abort at any point; an aborted write never strobes.
- FSM states:
  - IDLE: on SS low, go to HDR.
  - HDR: the first rising edge captures R/W (1 = read, 0 = write). The next 7 rising edges shift the address in MSB first. o_ADDR updates as the bits arrive and equals the full address after the 8th rising edge. Then go to WDATA (write) or RLOAD (read).
  - WDATA: 32 rising edges shift into o_DATA_IN, MSB first. After the 32nd bit, o_DOUT_VALID is high for exactly one SYSCLK cycle, no later than 2 SYSCLK cycles after that edge is detected. Then go to DONE.
  - RLOAD: one SYSCLK cycle after entry, load the read shift register from the selected module word. o_MISO is the shift-register MSB. Go to RDATA.
  - RDATA: the first rising edge arms shifting. Each subsequent falling edge shifts left by one, shifting in 0. The master samples on falling edges and sees bit 31 first. After 32 falling edges, go to DONE.
  - DONE: ignore BCLK until SS goes high.
- The falling edge that ends the address phase never shifts read data.
- The master may stall BCLK arbitrarily between the header and the data. The minimum gap from the last header rising edge to the first data rising edge is BUFFER_WIDTH+3 SYSCLK periods.
- Module select: address value a in 1..N_MODULES selects module a-1.
  - Read data: that module's slice.
  - Write: o_MODULE_WE = 1<<(a-1), gated by o_DOUT_VALID; 0 otherwise.
  - Examples: addr 1 gives WE 0001; addr 4 gives WE 1000.
  - Address 0 or above N_MODULES: read returns 0, no WE.
- Extra BCLK edges after a complete frame, while SS is still low, are ignored.

Optional Feature:
- BDSPI_FRAME_ERR_EN defined: adds output o_FRAME_ERR (1 bit).
  - Set sticky when SS deasserts in HDR, WDATA, RLOAD or RDATA (an incomplete frame).
  - Cleared by the first rising edge of the next frame, or by reset.
- Not defined: the port does not exist and aborts are silent.

Decomposition:
- Package bdspi_pkg: the FSM state enum (IDLE, HDR, WDATA, RLOAD, RDATA, DONE) and the R/W flag encoding localparams.
- Sub-module bdspi_sync: BUFFER_WIDTH-deep synchronizer plus BCLK rise/fall edge detector, instantiated once.
- Module decode and mux stay inline.

Test Plan:
- Read addr 1..4 with module words 0x11111111, 0x22222222, 0x44444444, 0x88888888, BCLK stalled 150 ns after the header -> 32 MISO bits captured on falling edges equal the module word.
- Write addr 1 data 0x12345678 -> o_ADDR=1 after the header, o_DOUT_VALID low throughout the frame, then a single 1-cycle pulse with o_DATA_IN=0x12345678 and o_MODULE_WE=0001; pulse gone the next cycle.
- Writes to addr 2/3/4 with 0xF0F0F0F0, 0x00000000, 0xFFFFFFFF -> WE 0010/0100/1000 and matching o_DATA_IN.
- Repeat all reads and writes at a BCLK half-period of 6 and of 40 SYSCLK periods -> identical results.
- Read addr 0 and addr 7 -> MISO all zeros; write to addr 5 -> o_DOUT_VALID pulses, o_MODULE_WE stays 0.
- SS raised after 20 write data bits, then a full frame -> no strobe for the aborted write, the next frame succeeds, and o_FRAME_ERR is set then cleared (when BDSPI_FRAME_ERR_EN is defined).
